// File: rtl/write_back_unit.sv
// Write-back stage: retires ALU/store results directly and waits (with timeout) for load data.
// Optional instruction-retired counter port instret_o is enabled by defining WB_INSTRET_EN.
module write_back_unit #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            mem_bubble_i,
    input  logic [XLEN-1:0] mem_pc_i,
    input  logic [31:0]     mem_instruct_i,
    input  logic [4:0]      mem_rdt_addr_i,
    input  logic [XLEN-1:0] mem_rdt_wdata_i,
    input  logic            mem_is_mem_op_i,
    input  logic            mem_mem_op_type_i,
    input  logic [XLEN-1:0] mem_addr_i,
    output logic            mem_stall_o,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            retire_o,
    output logic [XLEN-1:0] retire_pc_o,
    output logic            load_err_o
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret_o
`endif
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;
    localparam int   CW     = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(LOAD_TIMEOUT - 1);

    logic            state;
    logic [CW-1:0]   wait_cnt;
    logic [XLEN-1:0] ld_pc;
    logic [2:0]      ld_funct3;
    logic [4:0]      ld_rd;
    logic [1:0]      ld_lane;
    logic            is_load;
    logic            unused_bits;

    assign unused_bits = ^{mem_instruct_i[31:15], mem_instruct_i[11:0], mem_addr_i[XLEN-1:2],
                           dmem_rdata_i[XLEN-1:XLEN-1]};
    assign is_load     = mem_is_mem_op_i && !mem_mem_op_type_i;
    assign mem_stall_o = (state == S_WAIT);

    // Misaligned lanes are tolerated: low address bits beyond the access size are ignored.
    function automatic logic [XLEN-1:0] extract(input logic [2:0] funct3, input logic [1:0] lane,
                                                input logic [XLEN-1:0] data);
        logic [7:0]      byte_v;
        logic [15:0]     half_v;
        logic [XLEN-1:0] res;
        byte_v = data[7:0];
        half_v = lane[1] ? data[31:16] : data[15:0];
        case (lane)
            2'd0:    byte_v = data[7:0];
            2'd1:    byte_v = data[15:8];
            2'd2:    byte_v = data[23:16];
            2'd3:    byte_v = data[31:24];
            default: byte_v = data[7:0];
        endcase
        case (funct3)
            3'b000:  res = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b100:  res = {{(XLEN-8){1'b0}}, byte_v};
            3'b001:  res = {{(XLEN-16){half_v[15]}}, half_v};
            3'b101:  res = {{(XLEN-16){1'b0}}, half_v};
            default: res = data;
        endcase
        return res;
    endfunction

    // Main FSM and registered write-back/retire outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            ld_pc       <= '0;
            ld_funct3   <= 3'd0;
            ld_rd       <= 5'd0;
            ld_lane     <= 2'd0;
            rf_we_o     <= 1'b0;
            rf_waddr_o  <= 5'd0;
            rf_wdata_o  <= '0;
            retire_o    <= 1'b0;
            retire_pc_o <= '0;
            load_err_o  <= 1'b0;
        end else begin
            rf_we_o  <= 1'b0;
            retire_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!mem_bubble_i) begin
                        if (is_load) begin
                            state     <= S_WAIT;
                            wait_cnt  <= '0;
                            ld_pc     <= mem_pc_i;
                            ld_funct3 <= mem_instruct_i[14:12];
                            ld_rd     <= mem_rdt_addr_i;
                            ld_lane   <= mem_addr_i[1:0];
                        end else begin
                            retire_o    <= 1'b1;
                            retire_pc_o <= mem_pc_i;
                            rf_we_o     <= !mem_is_mem_op_i && (mem_rdt_addr_i != 5'd0);
                            rf_waddr_o  <= mem_rdt_addr_i;
                            rf_wdata_o  <= mem_rdt_wdata_i;
                        end
                    end
                end
                S_WAIT: begin
                    // A response in the timeout cycle takes priority over the timeout.
                    if (dmem_rvalid_i) begin
                        state       <= S_IDLE;
                        retire_o    <= 1'b1;
                        retire_pc_o <= ld_pc;
                        rf_we_o     <= (ld_rd != 5'd0);
                        rf_waddr_o  <= ld_rd;
                        rf_wdata_o  <= extract(ld_funct3, ld_lane, dmem_rdata_i);
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= S_IDLE;
                        retire_o    <= 1'b1;
                        retire_pc_o <= ld_pc;
                        load_err_o  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    // Retired-instruction counter; wraps naturally at 2^64.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            instret_o <= 64'd0;
        end else if (retire_o) begin
            instret_o <= instret_o + 64'd1;
        end else begin
            instret_o <= instret_o;
        end
    end
`endif

endmodule

// File: tb/tb_write_back_unit.sv
// Randomized self-checking bench for write_back_unit against a transaction-level model.
module tb_write_back_unit;
    localparam int TO = 16;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        mem_bubble_i;
    logic [31:0] mem_pc_i;
    logic [31:0] mem_instruct_i;
    logic [4:0]  mem_rdt_addr_i;
    logic [31:0] mem_rdt_wdata_i;
    logic        mem_is_mem_op_i;
    logic        mem_mem_op_type_i;
    logic [31:0] mem_addr_i;
    logic        mem_stall_o;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        retire_o;
    logic [31:0] retire_pc_o;
    logic        load_err_o;
`ifdef WB_INSTRET_EN
    logic [63:0] instret_o;
`endif

    int          checks = 0;
    int          failures = 0;
    logic        err_model = 1'b0;
    longint      retires_model = 0;
    logic [31:0] last_pc = 32'd0;

    write_back_unit #(.XLEN(32), .LOAD_TIMEOUT(TO)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .mem_bubble_i(mem_bubble_i),
        .mem_pc_i(mem_pc_i), .mem_instruct_i(mem_instruct_i), .mem_rdt_addr_i(mem_rdt_addr_i),
        .mem_rdt_wdata_i(mem_rdt_wdata_i), .mem_is_mem_op_i(mem_is_mem_op_i),
        .mem_mem_op_type_i(mem_mem_op_type_i), .mem_addr_i(mem_addr_i), .mem_stall_o(mem_stall_o),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .retire_o(retire_o),
        .retire_pc_o(retire_pc_o), .load_err_o(load_err_o)
`ifdef WB_INSTRET_EN
        , .instret_o(instret_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference load extraction via shifts and signed integer conversion.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0]        sb;
        logic [31:0]        sh;
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        integer             x;
        sb  = rdata >> (8 * addr[1:0]);
        sh  = rdata >> (16 * addr[1]);
        b8  = sb[7:0];
        h16 = sh[15:0];
        case (f3)
            3'b000:  begin x = b8;  return x; end
            3'b100:  return sb & 32'h0000_00FF;
            3'b001:  begin x = h16; return x; end
            3'b101:  return sh & 32'h0000_FFFF;
            default: return rdata;
        endcase
    endfunction

    task automatic garble_mem();
        mem_bubble_i    = 1'b1;
        mem_pc_i        = $urandom;
        mem_instruct_i  = $urandom;
        mem_rdt_addr_i  = 5'($urandom);
        mem_rdt_wdata_i = $urandom;
        mem_addr_i      = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            garble_mem();
            dmem_rvalid_i = 1'($urandom);
            dmem_rdata_i  = $urandom;
            @(posedge clock_i);
            @(negedge clock_i);
            check_eq("idle_retire", retire_o, 1'b0);
            check_eq("idle_we", rf_we_o, 1'b0);
            check_eq("idle_stall", mem_stall_o, 1'b0);
            check_eq("idle_pc_hold", retire_pc_o, last_pc);
            check_eq("idle_err", load_err_o, err_model);
`ifdef WB_INSTRET_EN
            check_eq("instret", instret_o, retires_model);
`endif
        end
        dmem_rvalid_i = 1'b0;
    endtask

    // kind: 0 = ALU, 1 = store, 2 = load; delay = response-free wait cycles before rvalid.
    task automatic run_txn(input int kind, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] val, input int delay);
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        timeout;
        int          last;
        int          stall_cnt;
        pc  = $urandom & 32'hFFFF_FFFC;
        ins = $urandom & 32'hFFFF_8FFF;
        ins = ins | ({29'd0, f3} << 12);
        mem_bubble_i      = 1'b0;
        mem_pc_i          = pc;
        mem_instruct_i    = ins;
        mem_rdt_addr_i    = rd;
        mem_rdt_wdata_i   = (kind == 2) ? $urandom : val;
        mem_is_mem_op_i   = (kind != 0);
        mem_mem_op_type_i = (kind == 1);
        mem_addr_i        = addr;
        dmem_rvalid_i     = 1'b0;
        @(posedge clock_i);
        @(negedge clock_i);
        garble_mem();
        if (kind == 2) begin
            timeout   = (delay >= TO);
            last      = timeout ? TO : delay + 1;
            stall_cnt = 0;
            for (int k = 1; k <= last; k++) begin
                if (mem_stall_o) stall_cnt++;
                check_eq("wait_retire", retire_o, 1'b0);
                dmem_rvalid_i = (k == delay + 1);
                dmem_rdata_i  = (k == delay + 1) ? val : $urandom;
                @(posedge clock_i);
                @(negedge clock_i);
                garble_mem();
            end
            dmem_rvalid_i = 1'b0;
            check_eq("stall_cycles", stall_cnt, last);
            exp_we   = !timeout && (rd != 5'd0);
            exp_data = model_load(f3, addr, val);
            if (timeout) err_model = 1'b1;
        end else begin
            exp_we   = (kind == 0) && (rd != 5'd0);
            exp_data = val;
        end
        retires_model++;
        last_pc = pc;
        check_eq("retire", retire_o, 1'b1);
        check_eq("retire_pc", retire_pc_o, pc);
        check_eq("stall_after", mem_stall_o, 1'b0);
        check_eq("we", rf_we_o, exp_we);
        check_eq("load_err", load_err_o, err_model);
        if (exp_we) begin
            check_eq("waddr", rf_waddr_o, rd);
            check_eq("wdata", rf_wdata_o, exp_data);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        garble_mem();
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'd0;
        mem_is_mem_op_i   = 1'b0;
        mem_mem_op_type_i = 1'b0;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        check_eq("rst_retire", retire_o, 1'b0);
        check_eq("rst_we", rf_we_o, 1'b0);
        check_eq("rst_waddr", rf_waddr_o, 5'd0);
        check_eq("rst_wdata", rf_wdata_o, 32'd0);
        check_eq("rst_pc", retire_pc_o, 32'd0);
        check_eq("rst_err", load_err_o, 1'b0);
        check_eq("rst_stall", mem_stall_o, 1'b0);
        reset_i = 1'b0;
        idle_cycles(2);

        run_txn(0, 3'b000, 5'd5, 32'h0, 32'h0000_1234, 0);
        check_eq("add_wdata", rf_wdata_o, 32'h0000_1234);
        run_txn(2, 3'b000, 5'd7, 32'h0000_1003, 32'h80FF_FF01, 3);
        check_eq("lb_wdata", rf_wdata_o, 32'hFFFF_FF80);
        run_txn(2, 3'b101, 5'd8, 32'h0000_2002, 32'hBEEF_0000, 1);
        check_eq("lhu_wdata", rf_wdata_o, 32'h0000_BEEF);
        run_txn(1, 3'b010, 5'd9, 32'h0000_3000, 32'hDEAD_BEEF, 0);
        run_txn(0, 3'b000, 5'd0, 32'h0, 32'h5555_AAAA, 0);
        run_txn(2, 3'b000, 5'd0, 32'h0000_0001, 32'h1234_5678, 0);
        run_txn(2, 3'b010, 5'd10, 32'h0000_4003, 32'hCAFE_F00D, TO - 1);
        check_eq("rv_at_limit_err", load_err_o, 1'b0);
        run_txn(2, 3'b010, 5'd11, 32'h0000_5000, 32'h0BAD_0BAD, TO + 4);
        check_eq("timeout_err", load_err_o, 1'b1);
        idle_cycles(1);

        for (int t = 0; t < 80; t++) begin
            run_txn(int'($urandom_range(2, 0)), 3'($urandom), 5'($urandom), $urandom, $urandom,
                    int'($urandom_range(TO + 2, 0)));
            idle_cycles(int'($urandom_range(2, 0)));
        end

        // Reset while a load is pending, then a stray response.
        mem_bubble_i = 1'b0; mem_pc_i = 32'h0000_0100; mem_instruct_i = 32'h0000_2003;
        mem_rdt_addr_i = 5'd12; mem_is_mem_op_i = 1'b1; mem_mem_op_type_i = 1'b0;
        mem_addr_i = 32'h0; dmem_rvalid_i = 1'b0;
        @(posedge clock_i); @(negedge clock_i);
        garble_mem();
        check_eq("pre_rst_stall", mem_stall_o, 1'b1);
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b1;
        @(posedge clock_i); @(negedge clock_i);
        reset_i = 1'b0;
        check_eq("wrst_stall", mem_stall_o, 1'b0);
        check_eq("wrst_retire", retire_o, 1'b0);
        check_eq("wrst_we", rf_we_o, 1'b0);
        check_eq("wrst_err", load_err_o, 1'b0);
        check_eq("wrst_wdata", rf_wdata_o, 32'd0);
        check_eq("wrst_pc", retire_pc_o, 32'd0);
        err_model = 1'b0; last_pc = 32'd0; retires_model = 0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(posedge clock_i); @(negedge clock_i);
        dmem_rvalid_i = 1'b0;
        check_eq("stray_retire", retire_o, 1'b0);
        check_eq("stray_we", rf_we_o, 1'b0);
        check_eq("stray_stall", mem_stall_o, 1'b0);

        for (int r = 0; r < 10; r++) run_txn(0, 3'b000, 5'($urandom), 32'h0, $urandom, 0);
        idle_cycles(1);
`ifdef WB_INSTRET_EN
        check_eq("instret_10", instret_o, 64'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
